// File: rtl/wave_meas_pkg.sv
// Shared constants for the waveform measurement block: register offsets,
// CTRL/STATUS bit positions and the measurement FSM state codes.
package wave_meas_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_HIGH_LEN = 3'd2;
    localparam logic [2:0] ADDR_LOW_LEN  = 3'd3;
    localparam logic [2:0] ADDR_PERIOD   = 3'd4;
    localparam logic [2:0] ADDR_EDGES    = 3'd5;
    localparam logic [2:0] ADDR_MIN      = 3'd6;
    localparam logic [2:0] ADDR_MAX      = 3'd7;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;
    localparam int CTRL_POL = 2;

    localparam int STAT_DONE      = 0;
    localparam int STAT_OVF       = 1;
    localparam int STAT_STATE_LSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_HIGH = 2'b10,
        ST_LOW  = 2'b11
    } state_t;

endpackage

// File: rtl/wave_meas_if.sv
// Register bus for wave_meas: sel held until a one-cycle ready pulse,
// wstrb != 0 marks a write, rdata is valid only while ready is high.
interface wave_meas_if;
    logic        sel;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output sel, wstrb, addr, wdata, input rdata, ready);
    modport slave  (input sel, wstrb, addr, wdata, output rdata, ready);
endinterface

// File: rtl/wave_meas_sync_edge.sv
// Synchronizes an async input, optionally inverts it, and flags edges.
// Latency STAGES cycles to level; rise/fall are single-cycle strobes.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_d,
    input  logic i_inv,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_level;

    assign w_level = r_sync[STAGES-1] ^ i_inv;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;
endmodule

// File: rtl/wave_meas.sv
// Measures high/low/period lengths and edge count on wave_in[0] and tracks
// min/max of the raw wave_in word; each bus access completes in two cycles.
module wave_meas
    import wave_meas_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] wave_in,
    wave_meas_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_ready, r_en, r_pol, r_done, r_ovf;
    logic [31:0]      r_rdata, r_min, r_max, w_rd_mux;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt, r_high_len, r_low_len, r_period, r_edges, w_period_sat;
    logic [CNT_W:0]   w_sum;
    logic [2:0]       w_idx;
    logic             w_access, w_wr, w_ctrl_wr, w_clr, w_stat_rd;
    logic             w_level, w_rise, w_fall, w_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .resetn  (resetn),
        .i_d     (wave_in[0]),
        .i_inv   (r_pol),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // An access is taken on the edge where sel is seen with ready low; writes,
    // clr and the STATUS read-clear all act on that same edge.
    assign w_idx     = bus.addr[4:2];
    assign w_access  = bus.sel & ~r_ready;
    assign w_wr      = |bus.wstrb;
    assign w_ctrl_wr = w_access & w_wr & (w_idx == ADDR_CTRL);
    assign w_clr     = w_ctrl_wr & bus.wdata[CTRL_CLR];
    assign w_stat_rd = w_access & ~w_wr & (w_idx == ADDR_STATUS);
    assign w_unused  = ^{bus.addr[31:5], bus.addr[1:0], bus.wdata[31:3], w_level};

    assign w_sum        = {1'b0, r_high_len} + {1'b0, r_cnt};
    assign w_period_sat = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];

    always_comb begin
        w_rd_mux = '0;
        case (w_idx)
            ADDR_CTRL: begin
                w_rd_mux[CTRL_EN]  = r_en;
                w_rd_mux[CTRL_POL] = r_pol;
            end
            ADDR_STATUS: begin
                w_rd_mux[STAT_DONE]               = r_done;
                w_rd_mux[STAT_OVF]                = r_ovf;
                w_rd_mux[STAT_STATE_LSB +: 2]     = r_state;
            end
            ADDR_HIGH_LEN: w_rd_mux = 32'(r_high_len);
            ADDR_LOW_LEN:  w_rd_mux = 32'(r_low_len);
            ADDR_PERIOD:   w_rd_mux = 32'(r_period);
            ADDR_EDGES:    w_rd_mux = 32'(r_edges);
            ADDR_MIN:      w_rd_mux = r_min;
            default:       w_rd_mux = r_max;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_en    <= 1'b0;
            r_pol   <= 1'b0;
        end else begin
            r_ready <= w_access;
            r_rdata <= (w_access & ~w_wr) ? w_rd_mux : '0;
            if (w_ctrl_wr) begin
                r_en  <= bus.wdata[CTRL_EN];
                r_pol <= bus.wdata[CTRL_POL];
            end
        end
    end

    // Later assignments win, so a capture/overflow on the read-clear edge keeps its flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_high_len <= '0;
            r_low_len  <= '0;
            r_period   <= '0;
            r_edges    <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_clr) begin
            r_state    <= bus.wdata[CTRL_EN] ? ST_ARM : ST_IDLE;
            r_cnt      <= '0;
            r_high_len <= '0;
            r_low_len  <= '0;
            r_period   <= '0;
            r_edges    <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_stat_rd) begin
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
            end
            if (r_state != ST_IDLE && w_rise && r_edges != CNT_MAX)
                r_edges <= r_edges + CNT_W'(1);
            if (!r_en) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_ARM;
                    ST_ARM: if (w_rise) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= CNT_W'(1);
                    end
                    ST_HIGH: if (w_fall) begin
                        r_high_len <= r_cnt;
                        r_cnt      <= CNT_W'(1);
                        r_state    <= ST_LOW;
                    end else if (r_cnt == CNT_MAX) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    default: if (w_rise) begin
                        r_low_len <= r_cnt;
                        r_period  <= w_period_sat;
                        r_done    <= 1'b1;
                        r_cnt     <= CNT_W'(1);
                        r_state   <= ST_HIGH;
                    end else if (r_cnt == CNT_MAX) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_min <= '1;
            r_max <= '0;
        end else if (w_clr) begin
            r_min <= '1;
            r_max <= '0;
        end else if (r_en) begin
            if (wave_in < r_min) r_min <= wave_in;
            if (wave_in > r_max) r_max <= wave_in;
        end
    end

    assign bus.ready = r_ready;
    assign bus.rdata = r_rdata;
endmodule

// File: doc/wave_meas.md
WAVE_MEAS -- requirements
Module: wave_meas

Interface
REQ-001 Parameter CNT_W, default 32, width of all length/edge counters (16..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on wave_in[0] (2..3).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 wave_in  input  32  signal under measurement; bit 0 is the pulse input, full word is the sample input.
REQ-006 sel  input  1  bus access strobe, held until ready.
REQ-007 wstrb  input  4  byte write enables; any bit set means write, all zero means read.
REQ-008 addr  input  32  byte address; only addr[4:2] decoded.
REQ-009 wdata  input  32  write data.
REQ-010 rdata  output  32  read data, valid while ready=1.
REQ-011 ready  output  1  access-complete pulse.

Function
REQ-012 Register map on addr[4:2]: 0 CTRL (rw), 1 STATUS, 2 HIGH_LEN, 3 LOW_LEN, 4 PERIOD, 5 EDGES, 6 MIN, 7 MAX (all except CTRL read-only; writes to read-only registers are ignored but acknowledged).
REQ-013 CTRL bits: [0] en, [1] clr (write-1 self-clearing, reads 0), [2] edge_pol (0 = measure high phase first from rising edge, 1 = invert wave_in[0] before measurement); other bits read 0.
REQ-014 STATUS bits: [0] done, [1] ovf, [3:2] FSM state code; other bits read 0.
REQ-015 Bus: ready pulses exactly one cycle, the cycle after sel is first sampled with ready=0; rdata holds the addressed register in that cycle and is 0 otherwise; back-to-back accesses take 2 cycles each.
REQ-016 wave_in[0] passes through SYNC_STAGES flops, then the optional inversion; edges are detected by comparing the result with its one-cycle-delayed copy.
REQ-017 FSM states: IDLE (00), ARM (01), HIGH (10), LOW (11).
REQ-018 IDLE -> ARM when en=1; any state -> IDLE in the cycle after en is written 0.
REQ-019 ARM -> HIGH on a rising edge; the counter loads 1 on that cycle.
REQ-020 HIGH -> LOW on a falling edge: HIGH_LEN <= count, counter loads 1.
REQ-021 LOW -> HIGH on a rising edge: LOW_LEN <= count, PERIOD <= HIGH_LEN + count (saturating), done <= 1, counter loads 1.
REQ-022 In HIGH/LOW, the counter increments each cycle without an edge; at all-ones it holds and sets ovf.
REQ-023 EDGES increments on every rising edge while not IDLE and saturates at all-ones.
REQ-024 While en=1, MIN <= min(MIN, wave_in) and MAX <= max(MAX, wave_in) every cycle (unsigned, unsynchronized word).
REQ-025 A STATUS read clears done and ovf in the ready cycle; if a new set event coincides with that read, the flag stays 1.
REQ-026 clr: counter, HIGH_LEN, LOW_LEN, PERIOD, EDGES and MAX -> 0, MIN -> all-ones, done/ovf -> 0, FSM -> ARM if en else IDLE; clr has priority over same-cycle capture events.
REQ-027 Registers narrower than 32 bits are zero-extended on read.

Reset
REQ-028 On resetn=0: CTRL=0, FSM=IDLE, synchronizer flops 0, counter/HIGH_LEN/LOW_LEN/PERIOD/EDGES/MAX=0, MIN=all-ones, done=ovf=0, ready=0, rdata=0.
REQ-029 Reset asserted mid-measurement discards the partial count; no capture register is updated by the reset.

Structure
REQ-030 Register offsets, CTRL/STATUS bit positions and FSM state codes live in the shared wave package/include, alongside the generator's mode/address constants.
REQ-031 The synchronizer plus edge detector is the one sub-module, sync_edge (outputs level, rise, fall).
REQ-032 Bus decode, FSM/counters and min/max tracking are separate always blocks in wave_meas.

Verification
REQ-033 Write CTRL=1, drive wave_in[0] 3 high/5 low repeatedly -> after second rising edge HIGH_LEN=3, LOW_LEN=5, PERIOD=8, STATUS.done=1.
REQ-034 Read STATUS twice after done -> first read 0x?D-style done=1 with state LOW/HIGH code, second read done=0; ready is exactly one cycle per access.
REQ-035 CNT_W=16, hold wave_in[0]=1 for 70000 cycles after arming -> counter saturates at 0xFFFF, ovf=1, HIGH_LEN=0xFFFF on the falling edge.
REQ-036 Drive wave_in samples 7, 2, 0x90000000, 5 with en=1 -> MIN=2... then 0 only if driven; MAX=0x90000000; write clr -> MIN=0xFFFFFFFF, MAX=0, EDGES=0.
REQ-037 Assert resetn low mid-HIGH phase, release -> all registers at reset values, FSM IDLE, first capture only after re-enable and a full new period.
REQ-038 edge_pol=1 with 2 high/6 low input -> HIGH_LEN=6, LOW_LEN=2, PERIOD=8.
